serial_tx: RTL
==============

Name: serial_tx

Overview:
- Parallel-in, serial-out byte transmitter with start/stop framing. It is the transmit end of the team's single-wire serial link.
- Takes a parallel word through a valid/ready handshake and shifts it out LSB first on a one-bit line.
- Uses the same synchronous reset and clock-enable conventions as the team's register primitives.
- Sits between a register/control block that produces words and the output pin driver.

Parameters:
- DATA_W, 8: number of data bits per frame; must be >= 1.
- CLKS_PER_BIT, 4: enabled clock cycles each serial bit is held; must be >= 1.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  clock enable; when low, all state, counters and outputs are frozen.
- tx_data  input  DATA_W  word to transmit; sampled only at acceptance.
- tx_valid  input  1  producer has a word on tx_data.
- tx_ready  output  1  combinational; equals (state==IDLE) && enable.
- tx_line  output  1  serial line; idles high.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse marking frame completion.

Behaviour:
- Reset (reset=1 at a rising edge; reset overrides enable):
  - state=IDLE, bit counter=0, cycle counter=0, shift register=0.
  - tx_line=1, busy=0, done=0.
  - tx_ready then follows enable.
- States: IDLE, START, DATA, STOP.
- Acceptance:
  - Occurs at a rising edge with tx_valid && tx_ready, i.e. IDLE and enable=1.
  - tx_data is latched into the shift register and state moves to START.
  - busy=1 and tx_line=0 from the next cycle.
  - tx_data changes after acceptance have no effect.
- Cycle counter:
  - Counts enabled cycles 0..CLKS_PER_BIT-1 within each bit.
  - On reaching CLKS_PER_BIT-1 it wraps to 0 and the bit advances.
- START: tx_line=0 for CLKS_PER_BIT enabled cycles, then DATA with bit index 0.
- DATA:
  - tx_line = shift register bit 0, i.e. LSB first.
  - At the end of each bit: shift right by one and increment the bit index.
  - After bit DATA_W-1 completes, go to STOP.
- STOP: tx_line=1 for CLKS_PER_BIT enabled cycles, then IDLE.
- Completion:
  - On the edge that leaves STOP, the module registers done=1, busy=0 and state=IDLE.
  - done is cleared at the next rising edge if enable=1. If enable=0 it stays frozen high until the next enabled edge or reset.
- Frame length: (DATA_W+2)*CLKS_PER_BIT enabled cycles from acceptance edge to the done edge.
- Back-to-back:
  - A word can be accepted in the same cycle done is high, since tx_ready=1 there.
  - This leaves exactly one idle-high cycle between the stop bit and the next start bit.
- tx_valid while busy: ignored, no queueing; tx_ready=0.
- enable low mid-frame:
  - tx_line holds its current value.
  - Counters and state do not advance, and the bit is stretched by the number of disabled cycles.
- enable low in IDLE: tx_ready=0 and no acceptance occurs.
- reset mid-frame: the frame is aborted. At the next edge tx_line=1, busy=0 and done=0, with no done pulse.
- Simultaneous reset and tx_valid: reset wins and no word is accepted.
- All outputs are registered except tx_ready.

Test Plan:
- DATA_W=8, CLKS_PER_BIT=4, enable=1, send 0xA5 at edge E0:
  - tx_line is 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles.
  - done is high for exactly 1 cycle after edge E0+40; busy is high for those 40 cycles.
- Back-to-back 0x00 then 0xFF with tx_valid held high:
  - Second accept occurs in the done cycle; exactly 1 idle-high cycle separates the frames.
  - Second frame: 0 start, eight 1s, 1 stop.
- Send 0x3C and drop enable for 3 cycles in the middle of data bit 2:
  - tx_line holds the value of bit 2, which is 1.
  - That bit lasts 7 cycles and done is delayed by exactly 3 cycles (edge E0+43).
- Assert reset for 1 cycle in the middle of data bit 4 of 0x81:
  - Next cycle: tx_line=1, busy=0, tx_ready=1, and no done pulse occurs.
  - A new 0x55 frame then transmits correctly.
- Pulse tx_valid with 0x12 while busy during a frame of 0xF0:
  - 0x12 is ignored and the 0xF0 bit sequence is unaffected.
  - With enable=0 in IDLE and tx_valid=1: tx_ready=0 and nothing is sent.
- CLKS_PER_BIT=1, DATA_W=1, send 1:
  - tx_line sequence is 0,1,1 over 3 cycles, then done for 1 cycle.

Source files
------------

// File: rtl/serial_tx.sv
// serial_tx: parallel-in, serial-out transmitter with start/stop framing.
// A word is accepted over a valid/ready handshake and shifted out LSB first
// as one low start bit, DATA_W data bits and one high stop bit. Each bit is
// held for CLKS_PER_BIT enabled clock cycles.
//
// Ports:
//   clock    : system clock, rising edge
//   reset    : synchronous, active-high reset (overrides enable)
//   enable   : clock enable; when low all state and outputs are frozen
//   tx_data  : word to transmit, sampled only at acceptance
//   tx_valid : producer has a word on tx_data
//   tx_ready : combinational, high in IDLE while enable is high
//   tx_line  : serial line, idles high (registered)
//   busy     : high while a frame is in flight (registered)
//   done     : one-cycle pulse on frame completion (registered)
module serial_tx #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_line,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cyc_cnt;
    logic [BIT_W-1:0]  bit_idx;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_shift;
    logic              bit_end;

    // Last enabled cycle of the current serial bit.
    assign bit_end     = (cyc_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign shreg_shift = shreg >> 1;
    assign tx_ready    = (state == IDLE) && enable;

    // Framing FSM; outputs are registered alongside the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cyc_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx_line <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (enable) begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        shreg   <= tx_data;
                        cyc_cnt <= '0;
                        bit_idx <= '0;
                        state   <= START;
                        tx_line <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        state   <= DATA;
                        tx_line <= shreg[0];
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        shreg   <= shreg_shift;
                        if (bit_idx == BIT_W'(DATA_W - 1)) begin
                            bit_idx <= '0;
                            state   <= STOP;
                            tx_line <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + BIT_W'(1);
                            tx_line <= shreg_shift[0];
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        state   <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx_line <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
